// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 (40 MHz pclk) timing constants and lock-FSM state encoding
// for the VGA timer and the receive-side decoder.
package vga_timing_pkg;

  localparam int unsigned VGA_H_TOTAL  = 1056;
  localparam int unsigned VGA_H_SYNC   = 128;
  localparam int unsigned VGA_H_BP     = 88;
  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_V_TOTAL  = 628;
  localparam int unsigned VGA_V_SYNC   = 4;
  localparam int unsigned VGA_V_BP     = 23;
  localparam int unsigned VGA_V_ACTIVE = 600;
  localparam logic        VGA_SYNC_POL = 1'b1;

  localparam int unsigned H_ACT_START = VGA_H_SYNC + VGA_H_BP;  // 216
  localparam int unsigned V_ACT_START = VGA_V_SYNC + VGA_V_BP;  // 27

  typedef logic [1:0] state_t;
  localparam state_t HUNT    = 2'd0;
  localparam state_t MEASURE = 2'd1;
  localparam state_t LOCKED  = 2'd2;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and pulses for one cycle when it enters its active level.
module vga_sync_edge #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic pulse
);

  logic sync_q;
  logic sync_prev;

  // Reset to the inactive level so a released reset does not fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= ~POL;
      sync_prev <= ~POL;
    end else begin
      sync_q    <= sync_in;
      sync_prev <= sync_q;
    end
  end

  assign pulse = (sync_q == POL) && (sync_prev != POL);

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA sink: recovers pixel coordinates from sync edges, verifies frame timing,
// exposes locked active pixels and captures the colour at a probe coordinate.
module vga_rx_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter logic        SYNC_POL = VGA_SYNC_POL
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] probe_x,
  input  logic [10:0] probe_y,
  output logic        locked,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [11:0] pix_rgb,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [7:0]  err_count
);

  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;

  logic        hs_edge, vs_edge;
  logic [11:0] rgb_q, rgb_d;
  logic [10:0] hcnt, vcnt;
  state_t      state, state_n;
  logic        skip_first, skip_n, err_inc;
  logic        sat, len_bad, line_bad, frame_bad;
  logic        active, show, probe_hit;
  logic [10:0] x_n, y_n;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs (.clk(pclk), .rst(rst), .sync_in(hs_in), .pulse(hs_edge));
  vga_sync_edge #(.POL(SYNC_POL)) u_vs (.clk(pclk), .rst(rst), .sync_in(vs_in), .pulse(vs_edge));

  // Colour takes two stages so it lines up with hcnt, which restarts one cycle after the edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_q <= '0;
      rgb_d <= '0;
    end else begin
      rgb_q <= rgb_in;
      rgb_d <= rgb_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (hs_edge)         hcnt <= '0;
      else if (hcnt != '1) hcnt <= hcnt + 11'd1;
      if (vs_edge)                    vcnt <= '0;
      else if (hs_edge && vcnt != '1) vcnt <= vcnt + 11'd1;
    end
  end

  assign sat       = (hcnt == '1);
  assign len_bad   = hs_edge && (({1'b0, hcnt} + 12'd1) != 12'(H_TOTAL))
                     && !((state == MEASURE) && skip_first);
  assign line_bad  = len_bad || sat;
  assign frame_bad = vs_edge && (({1'b0, vcnt} + 12'd1) != 12'(V_TOTAL));

  always_comb begin
    state_n = state;
    skip_n  = skip_first;
    err_inc = 1'b0;
    case (state)
      HUNT: begin
        if (vs_edge) begin
          state_n = MEASURE;
          skip_n  = 1'b1;
        end
      end
      MEASURE: begin
        if (hs_edge) skip_n = 1'b0;
        if (line_bad) begin
          state_n = HUNT;
        end else if (vs_edge) begin
          // A short/long frame restarts the measurement rather than dropping to HUNT.
          state_n = frame_bad ? MEASURE : LOCKED;
          skip_n  = frame_bad;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_n = HUNT;
          err_inc = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= HUNT;
      skip_first <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      skip_first <= skip_n;
      if (err_inc && err_count != '1) err_count <= err_count + 8'd1;
    end
  end

  assign locked = (state == LOCKED);

  assign active = (hcnt >= 11'(H_START)) && (hcnt < 11'(H_START + H_ACTIVE)) &&
                  (vcnt >= 11'(V_START)) && (vcnt < 11'(V_START + V_ACTIVE));
  assign x_n       = hcnt - 11'(H_START);
  assign y_n       = vcnt - 11'(V_START);
  assign show      = locked && active;
  assign probe_hit = show && (x_n == probe_x) && (y_n == probe_y);

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      probe_valid <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      probe_rgb   <= '0;
    end else begin
      pix_valid   <= show;
      frame_start <= show && (x_n == '0) && (y_n == '0);
      probe_valid <= probe_hit;
      if (show) begin
        pix_x   <= x_n;
        pix_y   <= y_n;
        pix_rgb <= rgb_d;
      end
      if (probe_hit) probe_rgb <= rgb_d;
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a scaled-down raster (40x60 lines) so
// several full frames fit in a short run; every pixel is checked against the source.
module tb_vga_rx_decoder;

  localparam int HT = 40, HSY = 4, HBP = 6, HACT = 24;
  localparam int VT = 60, VSY = 2, VBP = 3, VACT = 50;
  localparam int HST = HSY + HBP;
  localparam int VST = VSY + VBP;
  localparam int FR  = HT * VT;
  localparam int PIX = HACT * VACT;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_in = 1'b0, vs_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] probe_x = '0, probe_y = '0;
  logic        locked, frame_start, pix_valid, probe_valid;
  logic [10:0] pix_x, pix_y;
  logic [11:0] pix_rgb, probe_rgb;
  logic [7:0]  err_count;

  always #5 pclk = ~pclk;

  vga_rx_decoder #(
    .H_TOTAL(HT), .H_SYNC(HSY), .H_BP(HBP), .H_ACTIVE(HACT),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_BP(VBP), .V_ACTIVE(VACT), .SYNC_POL(1'b1)
  ) dut (
    .pclk(pclk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .rgb_in(rgb_in),
    .probe_x(probe_x), .probe_y(probe_y), .locked(locked), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid), .err_count(err_count)
  );

  typedef struct {
    int          px;
    int          py;
    logic        fixed;
    logic [11:0] fixed_col;
    int          exp_pulses;
    logic [11:0] exp_rgb;
  } probe_vec_t;

  probe_vec_t vecs[6];

  int checks = 0, errors = 0;
  int sh = 0, sv = 0, short_sv = -1, supp = 0;
  logic        fixed_en = 1'b0;
  logic [11:0] fixed_rgb = '0;
  int          h_sh[3], h_sv[3];
  logic [11:0] h_rgb[3];
  int          n_pv = 0, n_fs = 0, n_pr = 0;
  logic [11:0] rgb00 = '0, rgbend = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    logic [11:0] c;
    c      = fixed_en ? fixed_rgb : {4'(sh), 4'(sv), 4'hA};
    hs_in  = (supp > 0) ? 1'b0 : (sh < HSY);
    vs_in  = (sv < VSY);
    rgb_in = c;
    @(posedge pclk);
    #1;
    for (int i = 2; i > 0; i--) begin
      h_sh[i] = h_sh[i-1]; h_sv[i] = h_sv[i-1]; h_rgb[i] = h_rgb[i-1];
    end
    h_sh[0] = sh; h_sv[0] = sv; h_rgb[0] = c;
    if (supp > 0) supp--;
    sh++;
    if (sh >= ((sv == short_sv) ? HT - 1 : HT)) begin
      if (sv == short_sv) short_sv = -1;
      sh = 0;
      sv = (sv + 1) % VT;
    end
    if (pix_valid) begin
      n_pv++;
      chk("pix_x", pix_x, h_sh[2] - HST);
      chk("pix_y", pix_y, h_sv[2] - VST);
      chk("pix_rgb", pix_rgb, h_rgb[2]);
      if (pix_x == 0 && pix_y == 0) rgb00 = pix_rgb;
      if (pix_x == HACT - 1 && pix_y == VACT - 1) rgbend = pix_rgb;
    end
    if (frame_start) begin
      n_fs++;
      chk("frame_start_at_origin", int'(pix_valid && pix_x == 0 && pix_y == 0), 1);
    end
    if (probe_valid) begin
      n_pr++;
      chk("probe_rgb_eq_pix", probe_rgb, pix_rgb);
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_frame_start();
    int n;
    n = 0;
    while (!(sh == 0 && sv == 0) && n < FR + HT) begin
      step();
      n++;
    end
    if (!(sh == 0 && sv == 0)) chk("frame_align_timeout", 0, 1);
  endtask

  task automatic zero_counts();
    n_pv = 0; n_fs = 0; n_pr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_pix_rgb"}, pix_rgb, 0);
    chk({tag, "_probe_rgb"}, probe_rgb, 0);
    chk({tag, "_probe_valid"}, probe_valid, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{px: 0,  py: 0,  fixed: 1'b0, fixed_col: 12'h000, exp_pulses: 1, exp_rgb: 12'hA5A};
    vecs[1] = '{px: 23, py: 49, fixed: 1'b0, fixed_col: 12'h000, exp_pulses: 1, exp_rgb: 12'h16A};
    vecs[2] = '{px: 12, py: 25, fixed: 1'b0, fixed_col: 12'h000, exp_pulses: 1, exp_rgb: 12'h6EA};
    vecs[3] = '{px: 24, py: 0,  fixed: 1'b0, fixed_col: 12'h000, exp_pulses: 0, exp_rgb: 12'h6EA};
    vecs[4] = '{px: 0,  py: 50, fixed: 1'b0, fixed_col: 12'h000, exp_pulses: 0, exp_rgb: 12'h6EA};
    vecs[5] = '{px: 12, py: 25, fixed: 1'b1, fixed_col: 12'h5A3, exp_pulses: 1, exp_rgb: 12'h5A3};
    for (int i = 0; i < 3; i++) begin
      h_sh[i] = 0; h_sv[i] = 0; h_rgb[i] = '0;
    end

    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Lock lands two cycles after the second frame's first pixel is presented.
    run_steps(FR + 1);
    chk("locked_before_2nd_vs", locked, 0);
    step();
    chk("locked_at_2nd_vs", locked, 1);

    zero_counts();
    run_to_frame_start();
    chk("nominal_pix_count", n_pv, PIX);
    chk("nominal_frame_start", n_fs, 1);
    chk("nominal_err", err_count, 0);
    chk("rgb_first_pixel", rgb00, 12'hA5A);
    chk("rgb_last_pixel", rgbend, 12'h16A);

    for (int v = 0; v < 6; v++) begin
      probe_x   = 11'(vecs[v].px);
      probe_y   = 11'(vecs[v].py);
      fixed_en  = vecs[v].fixed;
      fixed_rgb = vecs[v].fixed_col;
      zero_counts();
      run_steps(FR);
      chk($sformatf("probe%0d_pulses", v), n_pr, vecs[v].exp_pulses);
      chk($sformatf("probe%0d_rgb", v), probe_rgb, vecs[v].exp_rgb);
      chk($sformatf("probe%0d_pix_count", v), n_pv, PIX);
      chk($sformatf("probe%0d_frame_start", v), n_fs, 1);
    end
    fixed_en = 1'b0;

    // Bad line: line 8 one cycle short, detected at the start of line 9.
    short_sv = 8;
    n = 0;
    while (locked && n < FR) begin
      step();
      n++;
    end
    chk("badline_drop_pos", sv * 100 + sh, 902);
    chk("badline_err", err_count, 1);
    run_to_frame_start();
    run_steps(FR + 1);
    chk("badline_relock_early", locked, 0);
    step();
    chk("badline_relock", locked, 1);
    chk("badline_err_after", err_count, 1);

    // Missing hsync from line 3: hcnt saturates 2048 cycles after line 2's edge.
    run_to_frame_start();
    run_steps(3 * HT);
    zero_counts();
    supp = 3000;
    run_steps(2009);
    chk("locked_before_sat", locked, 1);
    step();
    chk("locked_at_sat", locked, 0);
    run_steps(990);
    chk("nosync_pix_count", n_pv, 0);
    chk("nosync_err", err_count, 2);
    n = 0;
    while (!locked && n < 4 * FR) begin
      step();
      n++;
    end
    chk("nosync_relock", locked, 1);
    run_to_frame_start();
    zero_counts();
    run_steps(FR);
    chk("post_relock_pix_count", n_pv, PIX);
    chk("post_relock_frame_start", n_fs, 1);
    chk("post_relock_err", err_count, 2);

    // Reset at line 30 of a locked frame.
    run_steps(30 * HT);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midreset");
    run_to_frame_start();
    run_steps(FR + 1);
    chk("midreset_relock_early", locked, 0);
    step();
    chk("midreset_relock", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx_decoder.md
Name: vga_rx_decoder

Overview:
- Sink-side decoder for the VGA pixel stream the display pipeline drives: consumes hs/vs/{r,g,b} on pclk and recovers pixel coordinates from the sync edges.
- Checks the stream against 800x600@60 timing (40 MHz pclk) and declares lock.
- Exposes the active pixel with its x/y and captures the colour at one programmable probe coordinate.
- Sits on the far end of the VGA output: used as an on-chip loopback monitor and as the self-checking sink in benches.

Parameters:
- H_TOTAL, 1056, pclk cycles per line
- H_SYNC, 128, hsync pulse width
- H_BP, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- V_TOTAL, 628, lines per frame
- V_SYNC, 4, vsync pulse width in lines
- V_BP, 23, vertical back porch in lines
- V_ACTIVE, 600, visible lines
- SYNC_POL, 1, active level of hs/vs (1 = positive)

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- rgb_in  in  12  {r,g,b}, 4 bits each
- probe_x  in  11  probe column, 0..H_ACTIVE-1
- probe_y  in  11  probe row, 0..V_ACTIVE-1
- locked  out  1  timing verified
- frame_start  out  1  one-cycle pulse at pixel (0,0) when locked
- pix_valid  out  1  pix_* hold an active pixel
- pix_x  out  11  active column
- pix_y  out  11  active row
- pix_rgb  out  12  active pixel colour
- probe_rgb  out  12  last colour captured at the probe coordinate
- probe_valid  out  1  one-cycle pulse when probe_rgb updates
- err_count  out  8  timing violations, saturates at 255

Behaviour:
- Reset: all outputs 0; FSM in HUNT; counters 0.
- Input stage: hs_in, vs_in and rgb_in are registered once. An edge is detected when the registered sync reaches SYNC_POL and its previous sample was not SYNC_POL.
- Horizontal counter hcnt:
  - Set to 0 in the cycle the hs edge is detected; otherwise increments.
  - Saturates at 2047; never wraps.
- Vertical counter vcnt:
  - Increments on each hs edge.
  - Set to 0 on a vs edge.
  - If hs and vs edges coincide, vs wins and vcnt = 0.
- Line check: on each hs edge, the line is bad if hcnt+1 != H_TOTAL. The first hs edge after entering MEASURE is not checked.
- Frame check: on a vs edge, the frame is bad if vcnt+1 != V_TOTAL (vcnt at the edge, before it clears).
- FSM:
  - HUNT: on a vs edge, go to MEASURE.
  - MEASURE: any bad line goes to HUNT. On a vs edge with a good frame check and no bad line seen, go to LOCKED and set locked=1.
  - LOCKED: any bad line or bad frame increments err_count (saturating), clears locked and goes to HUNT in the same cycle.
  - hcnt at 2047, meaning no hs for 2048 cycles, counts as a bad line in all states.
- Active region: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - pix_x = hcnt-(H_SYNC+H_BP); pix_y = vcnt-(V_SYNC+V_BP).
- Pixel output: pix_valid = locked AND active region.
  - Latency: a pixel on rgb_in at edge n appears on pix_rgb at edge n+2.
  - When pix_valid=0, pix_x, pix_y and pix_rgb hold their last values.
- frame_start: pulses with pix_valid at pix_x=0, pix_y=0.
- Probe:
  - When pix_valid and pix_x==probe_x and pix_y==probe_y, latch probe_rgb and pulse probe_valid the same cycle.
  - probe_x/probe_y are sampled every cycle; an out-of-range probe never matches.
- Reset mid-frame: returns to HUNT and requires a full good frame before locked re-asserts.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 800x600 timing constants, shared with the Timer generator
  - the FSM state typedef {HUNT, MEASURE, LOCKED}
  - derived constants H_ACT_START=216, V_ACT_START=27
- One natural sub-module, vga_sync_edge: registers one sync input, applies polarity and emits a single-cycle edge pulse. It is instantiated twice (hs, vs).

Test Plan:
- Nominal: drive the Timer's 1056x628 stream, positive polarity, after rst → locked=1 at the second vs edge; pix_valid high exactly 480000 cycles per frame; err_count=0.
- Coordinate/latency: rgb_in = {hcnt[3:0], vcnt[3:0], 4'hA} → pix_rgb matches expected at pix_x=0,pix_y=0 and pix_x=799,pix_y=599, two cycles after the source; frame_start once per frame.
- Probe: probe_x=400, probe_y=300, pixel colour 12'h5A3 → probe_valid pulses once per frame, probe_rgb=12'h5A3.
- Bad line: one line of 1055 cycles while locked → locked drops at that hs edge, err_count=1; relock after the next full good frame.
- Missing sync: hold hs inactive for 3000 cycles → hcnt saturates, locked=0, err_count increments once, no pix_valid.
- Reset mid-frame at line 300 → all outputs 0 next cycle; locked stays 0 until one complete good frame is seen.
